// File: rtl/skew_feeder.sv
// Tile buffer and diagonal skew generator feeding the left and top edges of an
// N x N shift-MAC systolic array; pads, flushes, then pulses done per tile.
module skew_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_act,
  input  logic [N*W-1:0] in_wgt,
  output logic [N*W-1:0] left_out,
  output logic [N*W-1:0] up_out,
  output logic           feed_valid,
  output logic           busy,
  output logic           done,
  output logic [1:0]     dbg_state
);

  localparam int LCW = (N > 1) ? $clog2(N) : 1;
  localparam int TW  = $clog2(2 * N);

  localparam logic [LCW-1:0] LC_LAST       = LCW'(N - 1);
  localparam logic [TW-1:0]  T_FEED_LAST   = TW'(2 * N - 2);
  localparam logic [TW-1:0]  T_FLUSH_LAST  = TW'(2 * N - 3);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [LCW-1:0] lc_q, lc_d;
  logic [TW-1:0]  t_q, t_d;

  logic [N*W-1:0] act_buf_q [N];
  logic [N*W-1:0] wgt_buf_q [N];

  logic [N*W-1:0] left_q, left_d;
  logic [N*W-1:0] up_q, up_d;
  logic           feed_valid_q, feed_valid_d;
  logic           done_q, done_d;
  logic           accept;

  // Handshake: a pair transfers on a rising edge where in_valid and in_ready are
  // both high; in_ready depends on registered state only, never on in_valid.
  assign in_ready  = (state_q == S_LOAD);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_LOAD);
  assign dbg_state = state_q;

  assign left_out   = left_q;
  assign up_out     = up_q;
  assign feed_valid = feed_valid_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      lc_q    <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    t_d     = t_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (lc_q == LC_LAST) begin
            state_d = S_FEED;
            lc_d    = '0;
            t_d     = '0;
          end else begin
            lc_d = lc_q + 1'b1;
          end
        end
      end
      S_FEED: begin
        if (t_q == T_FEED_LAST) begin
          state_d = S_FLUSH;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (t_q == T_FLUSH_LAST) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
        lc_d    = '0;
        t_d     = '0;
      end
      default: begin
        state_d = S_LOAD;
        lc_d    = '0;
        t_d     = '0;
      end
    endcase
  end

  // Outputs are precomputed from the next step so they are registered yet line up
  // with the step: lane i shows row (t - i) of the buffer.  Row N-1 is written on
  // the FEED entry edge, but it is first needed at t = N-1 >= 1.
  always_comb begin
    left_d       = '0;
    up_d         = '0;
    feed_valid_d = (state_d == S_FEED);
    done_d       = (state_d == S_DONE);
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_d == TW'(k + i)) begin
            left_d[i*W +: W] = act_buf_q[k][i*W +: W];
            up_d[i*W +: W]   = wgt_buf_q[k][i*W +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q       <= '0;
      up_q         <= '0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      left_q       <= left_d;
      up_q         <= up_d;
      feed_valid_q <= feed_valid_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        act_buf_q[k] <= '0;
        wgt_buf_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (accept && (lc_q == LCW'(k))) begin
          act_buf_q[k] <= in_act;
          wgt_buf_q[k] <= in_wgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed testbench for skew_feeder with N = 4, W = 8.
module tb_skew_feeder;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_act;
  logic [N*W-1:0] in_wgt;
  logic [N*W-1:0] left_out;
  logic [N*W-1:0] up_out;
  logic           feed_valid;
  logic           busy;
  logic           done;
  logic [1:0]     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]   tact [2][N][N];
  logic [W-1:0]   twgt [2][N][N];
  logic [N*W-1:0] exp_q [$];

  skew_feeder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .left_out  (left_out),
    .up_out    (up_out),
    .feed_valid(feed_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack_row(input int tl, input int k, input bit wgt);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = wgt ? twgt[tl][k][i] : tact[tl][k][i];
    return r;
  endfunction

  // Expected skewed edge at step t: lane i carries row t-i when that row exists.
  function automatic logic [N*W-1:0] exp_edge(input int tl, input int t, input bit wgt);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < N) r[i*W +: W] = wgt ? twgt[tl][k][i] : tact[tl][k][i];
    end
    return r;
  endfunction

  // driver: presents N rows back to back, leaves the bench at the t = 0 cycle
  task automatic load_tile(input int tl);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_act   = pack_row(tl, k, 1'b0);
      in_wgt   = pack_row(tl, k, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    in_act   = $urandom;
    in_wgt   = $urandom;
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_return_to_load got in_ready=%b exp=1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_act   = $urandom;
    in_wgt   = $urandom;
    #3;
    repeat (3) begin
      in_act = $urandom;
      in_wgt = $urandom;
      tick();
    end
    total += 6;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (left_out !== '0) begin bad++; $display("FAIL reset_left got=%h exp=0", left_out); end
    if (up_out !== '0) begin bad++; $display("FAIL reset_up got=%h exp=0", up_out); end
    if (feed_valid !== 1'b0) begin bad++; $display("FAIL reset_feed_valid got=%b exp=0", feed_valid); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL post_reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_basic();
    logic [N*W-1:0] e;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        tact[0][k][i] = W'(k * 4 + i + 1);
        twgt[0][k][i] = '0;
      end
    for (int t = 0; t < 15; t++) exp_q.push_back((t <= 6) ? exp_edge(0, t, 1'b0) : '0);
    load_tile(0);
    for (int c = 1; c <= 15; c++) begin
      e = exp_q.pop_front();
      total += 4;
      if (left_out !== e) begin bad++; $display("FAIL basic_left c=%0d got=%h exp=%h", c, left_out, e); end
      if (up_out !== '0) begin bad++; $display("FAIL basic_up c=%0d got=%h exp=0", c, up_out); end
      if (feed_valid !== (c <= 7)) begin bad++; $display("FAIL basic_feed_valid c=%0d got=%b exp=%b", c, feed_valid, (c <= 7)); end
      if (done !== (c == 14)) begin bad++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, (c == 14)); end
      if (c == 1) begin
        total++;
        if (left_out !== 32'h0000_0001) begin bad++; $display("FAIL basic_t0 got=%h exp=00000001", left_out); end
      end
      if (c == 4) begin
        total++;
        if (left_out !== 32'h0407_0A0D) begin bad++; $display("FAIL basic_t3 got=%h exp=04070a0d", left_out); end
      end
      if (c == 15) begin
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_reload_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_reload_busy got=%b exp=0", busy); end
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] acc;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        tact[0][k][j] = W'(2 * k + 3 + 16 * j);
        twgt[0][k][j] = W'((k + j) % 8);
      end
    acc = '0;
    load_tile(0);
    for (int t = 0; t <= 6; t++) begin
      total += 2;
      if (up_out !== exp_edge(0, t, 1'b1)) begin bad++; $display("FAIL shift_up t=%0d got=%h exp=%h", t, up_out, exp_edge(0, t, 1'b1)); end
      if (left_out !== exp_edge(0, t, 1'b0)) begin bad++; $display("FAIL shift_left t=%0d got=%h exp=%h", t, left_out, exp_edge(0, t, 1'b0)); end
      if (t == 3) begin
        total++;
        if (up_out !== 32'h0303_0303) begin bad++; $display("FAIL shift_t3 got=%h exp=03030303", up_out); end
      end
      if (t == 4) begin
        total++;
        if (up_out !== 32'h0404_0400) begin bad++; $display("FAIL shift_t4 got=%h exp=04040400", up_out); end
      end
      acc = acc + 8'(left_out[7:0] << up_out[3:0]);
      tick();
    end
    total++;
    if (acc !== 8'h71) begin bad++; $display("FAIL shift_cell00_acc got=%h exp=71", acc); end
    wait_load("shift");
  endtask

  task automatic test_stall();
    int sent;
    int cyc;
    bit acc;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        tact[0][k][i] = W'(8'hA0 + k * 4 + i);
        twgt[0][k][i] = W'(8'h50 + k * 4 + i);
      end
    sent = 0;
    cyc  = 0;
    while (sent < N && cyc < 30) begin
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_load_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
      in_valid = (cyc % 3 == 0);
      if (in_valid) begin
        in_act = pack_row(0, sent, 1'b0);
        in_wgt = pack_row(0, sent, 1'b1);
      end else begin
        in_act = $urandom;
        in_wgt = $urandom;
      end
      acc = in_valid;
      tick();
      if (acc) sent++;
      cyc++;
    end
    total++;
    if (cyc != 10) begin bad++; $display("FAIL stall_load_cycles got=%0d exp=10", cyc); end
    for (int t = 0; t <= 6; t++) begin
      total += 3;
      if (left_out !== exp_edge(0, t, 1'b0)) begin bad++; $display("FAIL stall_left t=%0d got=%h exp=%h", t, left_out, exp_edge(0, t, 1'b0)); end
      if (up_out !== exp_edge(0, t, 1'b1)) begin bad++; $display("FAIL stall_up t=%0d got=%h exp=%h", t, up_out, exp_edge(0, t, 1'b1)); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_feed_ready t=%0d got=%b exp=0", t, in_ready); end
      in_valid = 1'b1;
      in_act   = $urandom;
      in_wgt   = $urandom;
      tick();
    end
    in_valid = 1'b0;
    wait_load("stall");
  endtask

  task automatic test_back_to_back();
    int sent;
    bit acc;
    bit efv;
    logic [N*W-1:0] el;
    logic [N*W-1:0] eu;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        tact[0][k][j] = W'(8'h11 + k * 4 + j);
        twgt[0][k][j] = W'((k + j) % 8);
        tact[1][k][j] = W'(8'h80 + k * 4 + j);
        twgt[1][k][j] = W'(8'hF0 | (k * 4 + j));
      end
    sent = 0;
    for (int cyc = 0; cyc <= 36; cyc++) begin
      efv = (cyc >= 4 && cyc <= 10) || (cyc >= 22 && cyc <= 28);
      el  = '0;
      eu  = '0;
      if (cyc >= 4 && cyc <= 10) begin
        el = exp_edge(0, cyc - 4, 1'b0);
        eu = exp_edge(0, cyc - 4, 1'b1);
      end else if (cyc >= 22 && cyc <= 28) begin
        el = exp_edge(1, cyc - 22, 1'b0);
        eu = exp_edge(1, cyc - 22, 1'b1);
      end
      total += 5;
      if (feed_valid !== efv) begin bad++; $display("FAIL b2b_feed_valid cyc=%0d got=%b exp=%b", cyc, feed_valid, efv); end
      if (done !== (cyc == 17 || cyc == 35)) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 17 || cyc == 35)); end
      if (left_out !== el) begin bad++; $display("FAIL b2b_left cyc=%0d got=%h exp=%h", cyc, left_out, el); end
      if (up_out !== eu) begin bad++; $display("FAIL b2b_up cyc=%0d got=%h exp=%h", cyc, up_out, eu); end
      if (in_ready !== (cyc <= 3 || (cyc >= 18 && cyc <= 21) || cyc == 36)) begin
        bad++;
        $display("FAIL b2b_ready cyc=%0d got=%b", cyc, in_ready);
      end
      if (cyc == 22) begin
        total++;
        if (left_out !== 32'h0000_0080) begin bad++; $display("FAIL b2b_second_t0 got=%h exp=00000080", left_out); end
      end
      if (sent < 2 * N) begin
        in_valid = 1'b1;
        in_act   = pack_row(sent / N, sent % N, 1'b0);
        in_wgt   = pack_row(sent / N, sent % N, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      if (cyc < 36) begin
        tick();
        if (acc) sent++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (sent != 2 * N) begin bad++; $display("FAIL b2b_sent got=%0d exp=%0d", sent, 2 * N); end
  endtask

  task automatic test_midreset();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        tact[0][k][j] = W'(8'h30 + k * 4 + j);
        twgt[0][k][j] = W'(k ^ j);
        tact[1][k][j] = W'(8'h60 + k * 4 + j);
        twgt[1][k][j] = W'(k + j);
      end
    load_tile(0);
    repeat (3) tick();
    total++;
    if (left_out !== exp_edge(0, 3, 1'b0)) begin bad++; $display("FAIL midrst_pre_left got=%h exp=%h", left_out, exp_edge(0, 3, 1'b0)); end
    #2;
    reset = 1'b0;
    #1;
    total += 6;
    if (left_out !== '0) begin bad++; $display("FAIL midrst_left got=%h exp=0", left_out); end
    if (up_out !== '0) begin bad++; $display("FAIL midrst_up got=%h exp=0", up_out); end
    if (feed_valid !== 1'b0) begin bad++; $display("FAIL midrst_feed_valid got=%b exp=0", feed_valid); end
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total += 2;
      if (done !== 1'b0) begin bad++; $display("FAIL midrst_no_done c=%0d got=%b exp=0", c, done); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle_ready c=%0d got=%b exp=1", c, in_ready); end
    end
    load_tile(1);
    for (int t = 0; t <= 6; t++) begin
      total += 2;
      if (left_out !== exp_edge(1, t, 1'b0)) begin bad++; $display("FAIL midrst_tile_left t=%0d got=%h exp=%h", t, left_out, exp_edge(1, t, 1'b0)); end
      if (up_out !== exp_edge(1, t, 1'b1)) begin bad++; $display("FAIL midrst_tile_up t=%0d got=%h exp=%h", t, up_out, exp_edge(1, t, 1'b1)); end
      tick();
    end
    wait_load("midrst");
  endtask

  initial begin
    in_valid = 1'b0;
    in_act   = '0;
    in_wgt   = '0;
    reset    = 1'b0;
    test_reset();
    test_basic();
    test_shift();
    test_stall();
    test_back_to_back();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
